// File: rtl/udma_l2_responder.sv
// L2 stand-in for the uDMA ro/wo memory ports: one single-port SRAM shared by two
// req/gnt/rvalid initiators under round-robin arbitration, with an optional grant stall.
module udma_l2_responder #(
  parameter int unsigned L2_DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS     = 4096,
  parameter logic [31:0] BASE_ADDR     = 32'h1C000000,
  parameter int unsigned GNT_STALL     = 0
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_i,
  input  logic                       L2_ro_req_i,
  output logic                       L2_ro_gnt_o,
  input  logic                       L2_ro_wen_i,
  input  logic [31:0]                L2_ro_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] L2_ro_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   L2_ro_wdata_i,
  output logic                       L2_ro_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]   L2_ro_rdata_o,
  input  logic                       L2_wo_req_i,
  output logic                       L2_wo_gnt_o,
  input  logic                       L2_wo_wen_i,
  input  logic [31:0]                L2_wo_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] L2_wo_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   L2_wo_wdata_i,
  output logic                       L2_wo_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]   L2_wo_rdata_o,
  output logic                       err_o
);

  localparam int unsigned BE_WIDTH  = L2_DATA_WIDTH / 8;
  localparam int unsigned OFFSET    = $clog2(BE_WIDTH);
  localparam int unsigned IDX_WIDTH = $clog2(MEM_WORDS);
  localparam logic [3:0]  STALL     = 4'(GNT_STALL);
  localparam logic [31:0] WORDS     = 32'(MEM_WORDS);
  localparam logic [L2_DATA_WIDTH-1:0] ERR_WORD = {(L2_DATA_WIDTH/32){32'hDEADBEEF}};

  typedef enum logic {
    PORT_RO = 1'b0,
    PORT_WO = 1'b1
  } port_e;

  port_e rr_q;
  logic [3:0] ro_wait_q;
  logic [3:0] wo_wait_q;
  logic ro_elig;
  logic wo_elig;
  logic ro_gnt;
  logic wo_gnt;
  logic any_gnt;

  logic                     sel_wen;
  logic [31:0]              sel_addr;
  logic [BE_WIDTH-1:0]      sel_be;
  logic [L2_DATA_WIDTH-1:0] sel_wdata;
  logic [31:0]              offs;
  logic [31:0]              word_idx;
  logic                     in_range;
  logic [IDX_WIDTH-1:0]     mem_idx;
  logic [L2_DATA_WIDTH-1:0] resp_data;

  logic [L2_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                     ro_rvalid_q;
  logic                     wo_rvalid_q;
  logic [L2_DATA_WIDTH-1:0] ro_rdata_q;
  logic [L2_DATA_WIDTH-1:0] wo_rdata_q;
  logic                     err_q;

  // At most one grant per cycle; the rr pointer only breaks ties between eligible ports.
  always_comb begin
    ro_elig = L2_ro_req_i && (ro_wait_q >= STALL);
    wo_elig = L2_wo_req_i && (wo_wait_q >= STALL);
    ro_gnt  = 1'b0;
    wo_gnt  = 1'b0;
    if (!sys_rst_i) begin
      if (ro_elig && (!wo_elig || rr_q == PORT_RO)) begin
        ro_gnt = 1'b1;
      end else if (wo_elig) begin
        wo_gnt = 1'b1;
      end
    end
    any_gnt = ro_gnt | wo_gnt;
  end

  always_comb begin
    sel_wen   = wo_gnt ? L2_wo_wen_i   : L2_ro_wen_i;
    sel_addr  = wo_gnt ? L2_wo_addr_i  : L2_ro_addr_i;
    sel_be    = wo_gnt ? L2_wo_be_i    : L2_ro_be_i;
    sel_wdata = wo_gnt ? L2_wo_wdata_i : L2_ro_wdata_i;
    offs      = sel_addr - BASE_ADDR;
    word_idx  = offs >> OFFSET;
    in_range  = (sel_addr >= BASE_ADDR) && (word_idx < WORDS);
    mem_idx   = word_idx[IDX_WIDTH-1:0];
    resp_data = '0;
    if (sel_wen) begin
      resp_data = in_range ? mem[mem_idx] : ERR_WORD;
    end
  end

  // SRAM array is deliberately left unreset so data survives a responder reset.
  always_ff @(posedge sys_clk_i) begin
    if (any_gnt && !sel_wen && in_range) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (sel_be[b]) begin
          mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rr_q        <= PORT_RO;
      ro_wait_q   <= '0;
      wo_wait_q   <= '0;
      ro_rvalid_q <= 1'b0;
      wo_rvalid_q <= 1'b0;
      ro_rdata_q  <= '0;
      wo_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      ro_rvalid_q <= ro_gnt;
      wo_rvalid_q <= wo_gnt;
      if (ro_gnt) begin
        ro_rdata_q <= resp_data;
        rr_q       <= PORT_WO;
      end else if (wo_gnt) begin
        wo_rdata_q <= resp_data;
        rr_q       <= PORT_RO;
      end
      if (any_gnt && !in_range) begin
        err_q <= 1'b1;
      end
      if (L2_ro_req_i && !ro_gnt) begin
        ro_wait_q <= (ro_wait_q == 4'd15) ? ro_wait_q : ro_wait_q + 4'd1;
      end else begin
        ro_wait_q <= '0;
      end
      if (L2_wo_req_i && !wo_gnt) begin
        wo_wait_q <= (wo_wait_q == 4'd15) ? wo_wait_q : wo_wait_q + 4'd1;
      end else begin
        wo_wait_q <= '0;
      end
    end
  end

  assign L2_ro_gnt_o    = ro_gnt;
  assign L2_wo_gnt_o    = wo_gnt;
  assign L2_ro_rvalid_o = ro_rvalid_q;
  assign L2_wo_rvalid_o = wo_rvalid_q;
  assign L2_ro_rdata_o  = ro_rdata_q;
  assign L2_wo_rdata_o  = wo_rdata_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_udma_l2_responder.sv
// Randomized scoreboard bench for udma_l2_responder: a word-array model predicts every
// response, a monitor checks rvalid/rdata/err; a second instance exercises the grant stall.
module tb_udma_l2_responder;

  localparam logic [31:0] BASE  = 32'h1C000000;
  localparam int          WORDS = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ro_req = 0, ro_wen = 0, wo_req = 0, wo_wen = 0;
  logic [31:0] ro_addr = 0, ro_wdata = 0, wo_addr = 0, wo_wdata = 0;
  logic [3:0]  ro_be = 0, wo_be = 0;
  logic        ro_gnt, wo_gnt, ro_rvalid, wo_rvalid, err;
  logic [31:0] ro_rdata, wo_rdata;

  logic        s_req = 0, s_wen = 0;
  logic [31:0] s_addr = 0;
  logic        s_gnt, s_rvalid, s_wo_gnt, s_wo_rvalid, s_err;
  logic [31:0] s_rdata, s_wo_rdata;

  udma_l2_responder #(.L2_DATA_WIDTH(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE), .GNT_STALL(0)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .L2_ro_req_i(ro_req), .L2_ro_gnt_o(ro_gnt), .L2_ro_wen_i(ro_wen), .L2_ro_addr_i(ro_addr),
    .L2_ro_be_i(ro_be), .L2_ro_wdata_i(ro_wdata), .L2_ro_rvalid_o(ro_rvalid), .L2_ro_rdata_o(ro_rdata),
    .L2_wo_req_i(wo_req), .L2_wo_gnt_o(wo_gnt), .L2_wo_wen_i(wo_wen), .L2_wo_addr_i(wo_addr),
    .L2_wo_be_i(wo_be), .L2_wo_wdata_i(wo_wdata), .L2_wo_rvalid_o(wo_rvalid), .L2_wo_rdata_o(wo_rdata),
    .err_o(err)
  );

  udma_l2_responder #(.L2_DATA_WIDTH(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE), .GNT_STALL(3)) dut_stall (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .L2_ro_req_i(s_req), .L2_ro_gnt_o(s_gnt), .L2_ro_wen_i(s_wen), .L2_ro_addr_i(s_addr),
    .L2_ro_be_i(4'hF), .L2_ro_wdata_i(32'h0), .L2_ro_rvalid_o(s_rvalid), .L2_ro_rdata_o(s_rdata),
    .L2_wo_req_i(1'b0), .L2_wo_gnt_o(s_wo_gnt), .L2_wo_wen_i(1'b1), .L2_wo_addr_i(BASE),
    .L2_wo_be_i(4'h0), .L2_wo_wdata_i(32'h0), .L2_wo_rvalid_o(s_wo_rvalid), .L2_wo_rdata_o(s_wo_rdata),
    .err_o(s_err)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  txn_t ro_pend[$], wo_pend[$];
  exp_t ro_sb[$], wo_sb[$];
  txn_t cur_ro, cur_wo;
  bit   ro_busy = 0, wo_busy = 0, rand_gaps = 0;
  logic [31:0] model[int];
  bit   model_err = 0;
  bit   rr_wo = 0;
  int   errors = 0, checks = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour of one completed handshake: word-addressed array plus sticky error.
  task automatic processHandshake(input txn_t t, output exp_t e);
    int          idx;
    logic [31:0] word;
    bit          ok;
    ok  = (t.addr >= BASE) && (((t.addr - BASE) >> 2) < WORDS);
    idx = int'((t.addr - BASE) >> 2);
    e.data = 32'h0;
    if (!ok) begin
      model_err = 1;
      if (t.wen) e.data = 32'hDEADBEEF;
    end else if (t.wen) begin
      e.data = model.exists(idx) ? model[idx] : 32'h0;
    end else begin
      word = model.exists(idx) ? model[idx] : 32'h0;
      for (int b = 0; b < 4; b++) if (t.be[b]) word[b*8 +: 8] = t.wdata[b*8 +: 8];
      model[idx] = word;
    end
    e.err = model_err;
    e.cyc = cyc;
  endtask

  // One bus cycle: launch pending requests, then at the falling edge check arbitration.
  task automatic applyStimulus();
    bit   exp_ro, exp_wo;
    exp_t e;
    if (!ro_busy) begin
      if (ro_pend.size() > 0 && (!rand_gaps || $urandom_range(3) != 0)) begin
        cur_ro = ro_pend.pop_front();
        ro_busy = 1;
        ro_req = 1; ro_wen = cur_ro.wen; ro_addr = cur_ro.addr; ro_be = cur_ro.be; ro_wdata = cur_ro.wdata;
      end else begin
        ro_req = 0; ro_wen = 1'($urandom); ro_addr = $urandom; ro_be = 4'($urandom); ro_wdata = $urandom;
      end
    end
    if (!wo_busy) begin
      if (wo_pend.size() > 0 && (!rand_gaps || $urandom_range(3) != 0)) begin
        cur_wo = wo_pend.pop_front();
        wo_busy = 1;
        wo_req = 1; wo_wen = cur_wo.wen; wo_addr = cur_wo.addr; wo_be = cur_wo.be; wo_wdata = cur_wo.wdata;
      end else begin
        wo_req = 0; wo_wen = 1'($urandom); wo_addr = $urandom; wo_be = 4'($urandom); wo_wdata = $urandom;
      end
    end
    @(negedge clk);
    exp_ro = ro_req && (!wo_req || !rr_wo);
    exp_wo = wo_req && (!ro_req || rr_wo);
    checkOutput("gnt_ro", 32'(ro_gnt), 32'(exp_ro));
    checkOutput("gnt_wo", 32'(wo_gnt), 32'(exp_wo));
    if (ro_req && ro_gnt) begin
      processHandshake(cur_ro, e);
      ro_sb.push_back(e);
      ro_busy = 0;
      rr_wo = 1;
    end else if (wo_req && wo_gnt) begin
      processHandshake(cur_wo, e);
      wo_sb.push_back(e);
      wo_busy = 0;
      rr_wo = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    while ((ro_pend.size() > 0 || wo_pend.size() > 0 || ro_busy || wo_busy ||
            ro_sb.size() > 0 || wo_sb.size() > 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  function automatic txn_t mkTxn(input logic wen, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata);
    txn_t t;
    t.wen = wen; t.addr = addr; t.be = be; t.wdata = wdata;
    return t;
  endfunction

  // Monitor: every rvalid must match the oldest prediction and arrive one cycle after its grant.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ro_rvalid) begin
        if (ro_sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL rvalid_ro: got unexpected rvalid, required none");
        end else begin
          e = ro_sb.pop_front();
          checkOutput("rdata_ro", ro_rdata, e.data);
          checkOutput("latency_ro", cyc, e.cyc + 1);
          checkOutput("err_ro", 32'(err), 32'(e.err));
        end
      end else if (ro_sb.size() > 0 && ro_sb[0].cyc < cyc - 1) begin
        e = ro_sb.pop_front();
        checks++; errors++;
        $display("[TB] FAIL rvalid_ro: got no response, required one for grant at cycle %0d", e.cyc);
      end
      if (wo_rvalid) begin
        if (wo_sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL rvalid_wo: got unexpected rvalid, required none");
        end else begin
          e = wo_sb.pop_front();
          checkOutput("rdata_wo", wo_rdata, e.data);
          checkOutput("latency_wo", cyc, e.cyc + 1);
          checkOutput("err_wo", 32'(err), 32'(e.err));
        end
      end else if (wo_sb.size() > 0 && wo_sb[0].cyc < cyc - 1) begin
        e = wo_sb.pop_front();
        checks++; errors++;
        $display("[TB] FAIL rvalid_wo: got no response, required one for grant at cycle %0d", e.cyc);
      end
    end
  end

  initial begin
    logic [31:0] a;
    rst = 1;
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt_ro", 32'(ro_gnt), 0);
    checkOutput("rst_gnt_wo", 32'(wo_gnt), 0);
    checkOutput("rst_rvalid_ro", 32'(ro_rvalid), 0);
    checkOutput("rst_rvalid_wo", 32'(wo_rvalid), 0);
    checkOutput("rst_rdata_ro", ro_rdata, 0);
    checkOutput("rst_rdata_wo", wo_rdata, 0);
    checkOutput("rst_err", 32'(err), 0);
    @(posedge clk); #1 rst = 0;

    // Grant stall of 3: request from cycle 0, grant in cycle 3, response in cycle 4.
    @(negedge clk);
    s_req = 1; s_wen = 1; s_addr = BASE + 32'h40;
    #1 checkOutput("stall_gnt_c0", 32'(s_gnt), 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_gnt_c%0d", k), 32'(s_gnt), 32'(k == 3));
    end
    @(posedge clk); #1 s_req = 0;
    @(negedge clk) checkOutput("stall_rvalid_c4", 32'(s_rvalid), 1);
    @(negedge clk) checkOutput("stall_rvalid_c5", 32'(s_rvalid), 0);
    checkOutput("stall_err", 32'(s_err), 0);
    @(posedge clk); #1;

    rand_gaps = 0;
    for (int i = 0; i < 16; i++) ro_pend.push_back(mkTxn(0, BASE + 32'(i * 4), 4'hF, $urandom));
    runUntilIdle(200);

    ro_pend.push_back(mkTxn(0, BASE + 32'h10, 4'hF, 32'hA5A5A5A5));
    ro_pend.push_back(mkTxn(1, BASE + 32'h10, 4'h0, 32'h0));
    runUntilIdle(50);

    ro_pend.push_back(mkTxn(0, BASE + 32'h20, 4'hF, 32'h11223344));
    ro_pend.push_back(mkTxn(0, BASE + 32'h20, 4'b0101, 32'hFFFFFFFF));
    wo_pend.push_back(mkTxn(1, BASE + 32'h22, 4'h0, 32'h0));
    runUntilIdle(50);

    for (int i = 0; i < 6; i++) begin
      ro_pend.push_back(mkTxn(1, BASE + 32'($urandom_range(15) * 4), 4'h0, 32'h0));
      wo_pend.push_back(mkTxn(1, BASE + 32'($urandom_range(15) * 4), 4'h0, 32'h0));
    end
    runUntilIdle(50);

    rand_gaps = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(19) == 0)
        a = ($urandom_range(1) == 0) ? BASE + 32'(WORDS * 4) + 32'($urandom_range(63)) : BASE - 32'($urandom_range(1, 64));
      else
        a = BASE + 32'($urandom_range(15) * 4) + 32'($urandom_range(3));
      if ($urandom_range(1) == 0) ro_pend.push_back(mkTxn(1'($urandom), a, 4'($urandom), $urandom));
      else                        wo_pend.push_back(mkTxn(1'($urandom), a, 4'($urandom), $urandom));
    end
    runUntilIdle(5000);

    rand_gaps = 0;
    ro_pend.push_back(mkTxn(1, BASE + 32'(WORDS * 4), 4'h0, 32'h0));
    runUntilIdle(50);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", 32'(err), 1);
    @(posedge clk); #1;

    // Reset while a request is being granted: nothing must be answered afterwards.
    ro_req = 1; ro_wen = 1; ro_addr = BASE + 32'h10; wo_req = 0;
    @(negedge clk);
    checkOutput("gnt_before_reset", 32'(ro_gnt), 1);
    rst = 1;
    ro_busy = 0; wo_busy = 0; rr_wo = 0; model_err = 0;
    ro_sb.delete(); wo_sb.delete();
    @(negedge clk);
    checkOutput("reset_gnt_ro", 32'(ro_gnt), 0);
    checkOutput("reset_rvalid_ro", 32'(ro_rvalid), 0);
    checkOutput("reset_rvalid_wo", 32'(wo_rvalid), 0);
    checkOutput("reset_rdata_ro", ro_rdata, 0);
    checkOutput("reset_rdata_wo", wo_rdata, 0);
    checkOutput("reset_err", 32'(err), 0);
    @(posedge clk); #1;
    rst = 0; ro_req = 0;

    ro_pend.push_back(mkTxn(1, BASE + 32'h10, 4'h0, 32'h0));
    wo_pend.push_back(mkTxn(1, BASE + 32'h20, 4'h0, 32'h0));
    runUntilIdle(50);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
